// File: rtl/psram_pkg.sv
// psram_pkg: shared FSM state and requester types for the PSRAM command scheduler
package psram_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;
  typedef enum logic {REQ_RD, REQ_WR} req_t;
endpackage

// File: rtl/psram_chunk_calc.sv
// psram_chunk_calc: chunk length = min(remaining, bytes left in page, tCEM limit)
module psram_chunk_calc #(
  parameter int LEN_W      = 12,
  parameter int PAGE_BYTES = 1024,
  localparam int PW        = $clog2(PAGE_BYTES),
  localparam int CW        = LEN_W + 1
) (
  input  logic [PW-1:0]    offs,
  input  logic [CW-1:0]    rem,
  input  logic [LEN_W-1:0] cmax,
  output logic [CW-1:0]    chunk
);
  logic [CW-1:0] page_left, max_len, lim;
  assign page_left = CW'(PAGE_BYTES) - CW'(offs);
  assign max_len   = CW'(cmax) + CW'(1);
  assign lim       = page_left < max_len ? page_left : max_len;
  assign chunk     = rem < lim ? rem : lim;
endmodule

// File: rtl/psram_cmd_sched.sv
// psram_cmd_sched: arbitrates rd/wr requests and issues page/tCEM-legal chunks with tCPH gaps
module psram_cmd_sched
  import psram_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int LEN_W      = 12,
  parameter int PAGE_BYTES = 1024,
  parameter int GAP_W      = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [LEN_W-1:0]  cfg_max_i,
  input  logic [GAP_W-1:0]  cfg_gap_i,
  input  logic              rd_req_valid_i,
  output logic              rd_req_ready_o,
  input  logic [ADDR_W-1:0] rd_req_addr_i,
  input  logic [LEN_W-1:0]  rd_req_len_i,
  output logic              rd_done_o,
  input  logic              wr_req_valid_i,
  output logic              wr_req_ready_o,
  input  logic [ADDR_W-1:0] wr_req_addr_i,
  input  logic [LEN_W-1:0]  wr_req_len_i,
  output logic              wr_done_o,
  output logic              cmd_valid_o,
  input  logic              cmd_ready_i,
  output logic              cmd_we_o,
  output logic [ADDR_W-1:0] cmd_addr_o,
  output logic [LEN_W-1:0]  cmd_len_o,
  input  logic              phy_done_i,
  output logic              busy_o
);
  localparam int CW = LEN_W + 1;
  localparam int PW = $clog2(PAGE_BYTES);
  state_t            state, state_nxt;
  req_t              rr;
  logic [ADDR_W-1:0] addr;
  logic [CW-1:0]     rem, chunk;
  logic [LEN_W-1:0]  cmax;
  logic [GAP_W-1:0]  gap;
  logic              we, rd_gnt, wr_gnt, last;
  assign rd_gnt = state == IDLE && rd_req_valid_i && (!wr_req_valid_i || rr == REQ_RD);
  assign wr_gnt = state == IDLE && wr_req_valid_i && (!rd_req_valid_i || rr == REQ_WR);
  psram_chunk_calc #(.LEN_W(LEN_W), .PAGE_BYTES(PAGE_BYTES)) u_calc (
    .offs (addr[PW-1:0]),
    .rem  (rem),
    .cmax (cmax),
    .chunk(chunk)
  );
  // state register
  always_ff @(posedge clk_i)
    state <= rst_i ? IDLE : state_nxt;
  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = rd_gnt || wr_gnt ? ISSUE : IDLE;
      ISSUE:   state_nxt = cmd_ready_i ? WAIT : ISSUE;
      WAIT:    state_nxt = phy_done_i ? GAP : WAIT;
      default: state_nxt = gap != '0 ? GAP : rem != '0 ? ISSUE : IDLE;
    endcase
  end
  // request context: latched on accept, advanced per completed chunk, gap countdown
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr <= '0;
      rem  <= '0;
      we   <= 1'b0;
      cmax <= '0;
      gap  <= '0;
      rr   <= REQ_RD;
    end else begin
      if (rd_gnt || wr_gnt) begin
        addr <= wr_gnt ? wr_req_addr_i : rd_req_addr_i;
        rem  <= CW'(wr_gnt ? wr_req_len_i : rd_req_len_i) + CW'(1);
        we   <= wr_gnt;
        cmax <= cfg_max_i;
        rr   <= wr_gnt ? REQ_RD : REQ_WR;
      end
      if (state == WAIT && phy_done_i) begin
        addr <= addr + ADDR_W'(chunk);
        rem  <= rem - chunk;
        gap  <= cfg_gap_i;
      end
      if (state == GAP && gap != '0) gap <= gap - 1'b1;
    end
  end
  // outputs decoded from state and registered context
  always_comb begin
    last           = state == GAP && gap == '0 && rem == '0;
    rd_req_ready_o = rd_gnt;
    wr_req_ready_o = wr_gnt;
    cmd_valid_o    = state == ISSUE;
    cmd_we_o       = state == ISSUE && we;
    cmd_addr_o     = state == ISSUE ? addr : '0;
    cmd_len_o      = state == ISSUE ? LEN_W'(chunk - CW'(1)) : '0;
    rd_done_o      = last && !we;
    wr_done_o      = last && we;
    busy_o         = state != IDLE;
  end
endmodule

// File: tb/tb_psram_cmd_sched.sv
// tb_psram_cmd_sched: directed scoreboard bench for the PSRAM command scheduler
module tb_psram_cmd_sched;
  typedef struct packed {logic we; logic [31:0] addr; logic [11:0] len;} cmd_t;
  logic        clk = 1'b0, rst = 1'b1;
  logic [11:0] cfg_max = '0;
  logic [3:0]  cfg_gap = '0;
  logic        rd_valid = 1'b0, wr_valid = 1'b0, cmd_ready = 1'b0, phy_done = 1'b0;
  logic [31:0] rd_addr = '0, wr_addr = '0;
  logic [11:0] rd_len = '0, wr_len = '0;
  logic        rd_ready, wr_ready, rd_done, wr_done, cmd_valid, cmd_we, busy;
  logic [31:0] cmd_addr;
  logic [11:0] cmd_len;
  cmd_t        exp_q[$];
  logic        rr_m = 1'b0;
  int          checks = 0, errors = 0;

  psram_cmd_sched dut (
    .clk_i(clk), .rst_i(rst), .cfg_max_i(cfg_max), .cfg_gap_i(cfg_gap),
    .rd_req_valid_i(rd_valid), .rd_req_ready_o(rd_ready), .rd_req_addr_i(rd_addr),
    .rd_req_len_i(rd_len), .rd_done_o(rd_done),
    .wr_req_valid_i(wr_valid), .wr_req_ready_o(wr_ready), .wr_req_addr_i(wr_addr),
    .wr_req_len_i(wr_len), .wr_done_o(wr_done),
    .cmd_valid_o(cmd_valid), .cmd_ready_i(cmd_ready), .cmd_we_o(cmd_we),
    .cmd_addr_o(cmd_addr), .cmd_len_o(cmd_len), .phy_done_i(phy_done), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_chunks(input logic we, input logic [31:0] a, input int len, input int mx);
    int r, c, pl;
    r = len + 1;
    while (r > 0) begin
      pl = 1024 - int'(a % 1024);
      c = r;
      if (pl < c) c = pl;
      if (mx + 1 < c) c = mx + 1;
      exp_q.push_back({we, a, 12'(c - 1)});
      a = a + 32'(c);
      r = r - c;
    end
  endtask

  task automatic accept(input logic we, input logic [31:0] a, input int len, input int mx, input int g);
    @(negedge clk);
    cfg_max = 12'(mx);
    cfg_gap = 4'(g);
    if (we) begin wr_valid = 1'b1; wr_addr = a; wr_len = 12'(len); end
    else begin rd_valid = 1'b1; rd_addr = a; rd_len = 12'(len); end
    #1;
    chk("accept_ready", we ? wr_ready : rd_ready, 1);
    chk("accept_other_ready", we ? rd_ready : wr_ready, 0);
    chk("accept_no_cmd_yet", cmd_valid, 0);
    push_chunks(we, a, len, mx);
    rr_m = ~we;
    @(posedge clk);
    #1;
    rd_valid = 1'b0;
    wr_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic serve(input int g, input bit bp);
    cmd_t e;
    int k, spur;
    while (exp_q.size() > 0) begin
      k = 0;
      while (!cmd_valid && k < 50) begin @(negedge clk); k++; end
      chk("cmd_valid_wait", cmd_valid, 1);
      if (!cmd_valid) begin exp_q.delete(); return; end
      e = exp_q.pop_front();
      chk("cmd_we", cmd_we, e.we);
      chk("cmd_addr", cmd_addr, e.addr);
      chk("cmd_len", cmd_len, e.len);
      if (bp) repeat (10) begin
        @(negedge clk);
        chk("bp_valid", cmd_valid, 1);
        chk("bp_addr", cmd_addr, e.addr);
        chk("bp_len", cmd_len, e.len);
        chk("bp_we", cmd_we, e.we);
      end
      cmd_ready = 1'b1;
      @(negedge clk);
      cmd_ready = 1'b0;
      chk("wait_valid_low", cmd_valid, 0);
      repeat (2) @(negedge clk);
      chk("wait_busy", busy, 1);
      phy_done = 1'b1;
      @(negedge clk);
      phy_done = 1'b0;
      k = 0;
      spur = 0;
      if (exp_q.size() > 0) begin
        while (!cmd_valid && k < 50) begin
          if (rd_done || wr_done) spur++;
          @(negedge clk);
          k++;
        end
        chk("gap_idle_cycles", k, g + 1);
        chk("no_done_mid", spur, 0);
      end else begin
        while (!(rd_done || wr_done) && k < 50) begin @(negedge clk); k++; end
        chk("done_latency", k, g);
        chk("done_pulse", e.we ? wr_done : rd_done, 1);
        chk("done_other", e.we ? rd_done : wr_done, 0);
        @(negedge clk);
        chk("done_one_cycle", rd_done | wr_done, 0);
        chk("idle_after_done", busy, 0);
      end
    end
  endtask

  task automatic arb();
    logic g;
    @(negedge clk);
    cfg_max = 12'd255;
    cfg_gap = 4'd0;
    rd_valid = 1'b1; rd_addr = 32'h40; rd_len = 12'd0;
    wr_valid = 1'b1; wr_addr = 32'h80; wr_len = 12'd0;
    #1;
    g = rr_m;
    chk("arb_rd_ready", rd_ready, !g);
    chk("arb_wr_ready", wr_ready, g);
    push_chunks(g, g ? 32'h80 : 32'h40, 0, 255);
    rr_m = ~g;
    @(posedge clk);
    #1;
    rd_valid = 1'b0;
    wr_valid = 1'b0;
    @(negedge clk);
    serve(0, 0);
  endtask

  initial begin
    cmd_t e;
    int k;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_cmd_fields", {cmd_we, cmd_addr, cmd_len}, 0);
    chk("rst_done", {rd_done, wr_done}, 0);
    rst = 1'b0;
    accept(0, 32'h100, 63, 255, 2);
    chk("single_n", exp_q.size(), 1);
    serve(2, 0);
    accept(1, 32'h3F0, 31, 255, 1);
    chk("page_split_n", exp_q.size(), 2);
    serve(1, 0);
    accept(0, 32'h0, 1023, 127, 3);
    chk("tcem_split_n", exp_q.size(), 8);
    serve(3, 0);
    accept(1, 32'h7FC, 15, 255, 0);
    serve(0, 1);
    accept(0, 32'h200, 4095, 4095, 0);
    chk("max_len_n", exp_q.size(), 5);
    serve(0, 0);
    accept(1, 32'hFFFF_FFF8, 15, 255, 0);
    serve(0, 0);
    accept(0, 32'h0, 1023, 127, 1);
    e = exp_q.pop_front();
    chk("rstmid_c1_addr", cmd_addr, e.addr);
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    phy_done = 1'b1;
    @(negedge clk);
    phy_done = 1'b0;
    k = 0;
    while (!cmd_valid && k < 50) begin @(negedge clk); k++; end
    e = exp_q.pop_front();
    chk("rstmid_c2_addr", cmd_addr, e.addr);
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    exp_q.delete();
    rr_m = 1'b0;
    chk("rstmid_busy", busy, 0);
    chk("rstmid_cmd", {cmd_valid, cmd_we, cmd_addr, cmd_len}, 0);
    chk("rstmid_done", {rd_done, wr_done}, 0);
    phy_done = 1'b1;
    @(negedge clk);
    phy_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rstmid_quiet", {busy, cmd_valid, rd_done, wr_done}, 0);
    end
    accept(1, 32'h10, 0, 255, 0);
    serve(0, 0);
    repeat (4) arb();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
